step_dir_rx: RTL and testbench

- Receiving end of the step/dir pulse interface driven by the motion profile generator.
- Synchronises external step/dir inputs and accumulates a signed position count.
- Measures the step period in clk cycles, flags direction setup violations, and detects standstill by timeout.
- Used as a loopback checker against the generator's x, and as a follower/encoder input for a remote axis.

---
 rtl/step_dir_rx.sv | 177 +++++++++++++++++
 tb/tb_step_dir_rx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/step_dir_rx.sv
// Step/dir receiver: synchronises step/dir, accumulates signed position, measures step period.
// Optional glitch filter on the synced step level: define STEP_DIR_RX_GLITCH_FILTER_EN.
module step_dir_rx #(
  parameter int          PERIOD_W   = 24,
  parameter int          DIR_SETUP  = 4,
`ifdef STEP_DIR_RX_GLITCH_FILTER_EN
  parameter int          FILTER_LEN = 3,
`endif
  parameter int unsigned TIMEOUT    = 24'hFFFFFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                step_in,
  input  logic                dir_in,
  input  logic                load,
  input  logic signed [31:0]  pos_val,
  input  logic                err_clear,
  output logic signed [31:0]  pos,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                moving,
  output logic                cur_dir,
  output logic                step_seen,
  output logic                setup_err
);

  localparam int DSW = $clog2(DIR_SETUP + 1);
  localparam logic [DSW-1:0] DSETUP = DSW'(DIR_SETUP);
  localparam logic [PERIOD_W-1:0] TMO = PERIOD_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, FIRST, RUN} state_e;

  state_e               state_q, state_d;
  logic                 step_s1_q, step_s2_q, step_s3_q;
  logic                 dir_s1_q, dir_s2_q, dir_s3_q;
  logic [DSW-1:0]       dstab_q, dstab_d, dstabEff;
  logic [PERIOD_W-1:0]  cnt_q, cnt_d, period_q, period_d;
  logic signed [31:0]   pos_q, pos_d, posBase;
  logic                 pvalid_q, pvalid_d;
  logic                 moving_q, curdir_q, curdir_d, seen_q, err_q, err_d;
  logic                 stepLevel, stepEvent, dirChange, sameDir, timeout;

`ifdef STEP_DIR_RX_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam logic [FCW-1:0] FLAST = FCW'(FILTER_LEN - 1);

  logic           filt_q;
  logic [FCW-1:0] fcnt_q;

  // Filtered level follows s2 only after FILTER_LEN consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else if (step_s2_q == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FLAST) begin
      filt_q <= step_s2_q;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign stepLevel = filt_q;
`else
  assign stepLevel = step_s2_q;
`endif

  assign stepEvent = stepLevel & ~step_s3_q;

  always_comb begin
    dirChange = dir_s2_q ^ dir_s3_q;
    // A dir change in the step cycle itself must count as zero stable cycles.
    dstabEff  = dirChange ? '0 : dstab_q;
    dstab_d   = dirChange ? '0 : ((dstab_q == DSETUP) ? dstab_q : dstab_q + 1'b1);
    sameDir   = (dir_s2_q == curdir_q);
    timeout   = (cnt_q >= TMO);

    state_d  = state_q;
    period_d = period_q;
    pvalid_d = pvalid_q;
    curdir_d = stepEvent ? dir_s2_q : curdir_q;

    case (state_q)
      IDLE: begin
        pvalid_d = 1'b0;
        if (stepEvent) state_d = FIRST;
      end
      FIRST: begin
        if (stepEvent) begin
          if (sameDir) begin
            state_d  = RUN;
            period_d = cnt_q;
            pvalid_d = 1'b1;
          end
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (stepEvent) begin
          if (sameDir) begin
            period_d = cnt_q;
          end else begin
            state_d  = FIRST;
            pvalid_d = 1'b0;
          end
        end else if (timeout) begin
          state_d  = IDLE;
          pvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (stepEvent)                             cnt_d = {{(PERIOD_W-1){1'b0}}, 1'b1};
    else if (state_d == IDLE && state_q != IDLE) cnt_d = '0;
    else if (cnt_q == '1)                       cnt_d = cnt_q;
    else                                        cnt_d = cnt_q + 1'b1;

    posBase = load ? pos_val : pos_q;
    pos_d   = posBase;
    if (stepEvent) pos_d = dir_s2_q ? posBase + 32'sd1 : posBase - 32'sd1;

    err_d = err_q;
    if (stepEvent && (dstabEff < DSETUP)) err_d = 1'b1;
    else if (err_clear)                   err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_s1_q <= 1'b0;
      step_s2_q <= 1'b0;
      step_s3_q <= 1'b0;
      dir_s1_q  <= 1'b0;
      dir_s2_q  <= 1'b0;
      dir_s3_q  <= 1'b0;
      dstab_q   <= '0;
      cnt_q     <= '0;
      state_q   <= IDLE;
      period_q  <= '0;
      pvalid_q  <= 1'b0;
      moving_q  <= 1'b0;
      curdir_q  <= 1'b0;
      seen_q    <= 1'b0;
      err_q     <= 1'b0;
      pos_q     <= '0;
    end else begin
      step_s1_q <= step_in;
      step_s2_q <= step_s1_q;
      step_s3_q <= stepLevel;
      dir_s1_q  <= dir_in;
      dir_s2_q  <= dir_s1_q;
      dir_s3_q  <= dir_s2_q;
      dstab_q   <= dstab_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      period_q  <= period_d;
      pvalid_q  <= pvalid_d;
      moving_q  <= (state_d != IDLE);
      curdir_q  <= curdir_d;
      seen_q    <= stepEvent;
      err_q     <= err_d;
      pos_q     <= pos_d;
    end
  end

  assign pos          = pos_q;
  assign period       = period_q;
  assign period_valid = pvalid_q;
  assign moving       = moving_q;
  assign cur_dir      = curdir_q;
  assign step_seen    = seen_q;
  assign setup_err    = err_q;

endmodule

// File: tb/tb_step_dir_rx.sv
// Directed self-checking bench for step_dir_rx (default build, TIMEOUT=100).
module tb_step_dir_rx;

  logic               clk = 1'b0;
  logic               reset;
  logic               step_in, dir_in, load, err_clear;
  logic signed [31:0] pos_val;
  logic signed [31:0] pos;
  logic [23:0]        period;
  logic               period_valid, moving, cur_dir, step_seen, setup_err;

  int compared   = 0;
  int mismatched = 0;

  step_dir_rx #(.PERIOD_W(24), .DIR_SETUP(4), .TIMEOUT(100)) dut (
    .clk(clk), .reset(reset), .step_in(step_in), .dir_in(dir_in),
    .load(load), .pos_val(pos_val), .err_clear(err_clear),
    .pos(pos), .period(period), .period_valid(period_valid), .moving(moving),
    .cur_dir(cur_dir), .step_seen(step_seen), .setup_err(setup_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One step pulse: high cycles, then low cycles, dir untouched.
  task automatic applyStimulus(input int high, input int low);
    step_in = 1'b1;
    tick(high);
    step_in = 1'b0;
    tick(low);
  endtask

  initial begin
    reset = 1'b0; step_in = 1'b0; dir_in = 1'b1; load = 1'b0; err_clear = 1'b0; pos_val = '0;
    tick(3);
    checkOutput("rst_pos", pos, 32'h0);
    checkOutput("rst_period", {8'h0, period}, 32'h0);
    checkOutput("rst_pvalid", {31'h0, period_valid}, 32'h0);
    checkOutput("rst_moving", {31'h0, moving}, 32'h0);
    checkOutput("rst_curdir", {31'h0, cur_dir}, 32'h0);
    checkOutput("rst_seen", {31'h0, step_seen}, 32'h0);
    checkOutput("rst_err", {31'h0, setup_err}, 32'h0);
    reset = 1'b1;
    tick(10);

    // Five forward steps, first with latency check
    step_in = 1'b1;
    tick(2);
    checkOutput("lat_pos_early", pos, 32'h0);
    checkOutput("lat_seen_early", {31'h0, step_seen}, 32'h0);
    tick(1);
    checkOutput("lat_pos", pos, 32'h1);
    checkOutput("lat_seen", {31'h0, step_seen}, 32'h1);
    checkOutput("lat_curdir", {31'h0, cur_dir}, 32'h1);
    tick(1);
    checkOutput("seen_pulse_end", {31'h0, step_seen}, 32'h0);
    step_in = 1'b0;
    tick(16);
    checkOutput("s1_pvalid", {31'h0, period_valid}, 32'h0);
    checkOutput("s1_moving", {31'h0, moving}, 32'h1);
    for (int i = 2; i <= 5; i++) begin
      applyStimulus(4, 16);
      checkOutput($sformatf("s%0d_pvalid", i), {31'h0, period_valid}, 32'h1);
    end
    checkOutput("fwd_pos", pos, 32'd5);
    checkOutput("fwd_period", {8'h0, period}, 32'd20);
    checkOutput("fwd_err", {31'h0, setup_err}, 32'h0);

    // Reversal
    load = 1'b1; pos_val = 32'sd0;
    tick(1);
    load = 1'b0;
    checkOutput("load_zero", pos, 32'h0);
    applyStimulus(4, 16);
    applyStimulus(4, 16);
    applyStimulus(4, 6);
    checkOutput("rev_pre_pos", pos, 32'd3);
    dir_in = 1'b0;
    tick(10);
    applyStimulus(4, 16);
    checkOutput("rev1_pos", pos, 32'd2);
    checkOutput("rev1_pvalid", {31'h0, period_valid}, 32'h0);
    checkOutput("rev1_period_hold", {8'h0, period}, 32'd20);
    checkOutput("rev1_curdir", {31'h0, cur_dir}, 32'h0);
    checkOutput("rev1_moving", {31'h0, moving}, 32'h1);
    applyStimulus(4, 16);
    checkOutput("rev2_pos", pos, 32'd1);
    checkOutput("rev2_pvalid", {31'h0, period_valid}, 32'h1);
    checkOutput("rev2_period", {8'h0, period}, 32'd20);
    checkOutput("rev2_err", {31'h0, setup_err}, 32'h0);

    // Dir setup violation: dir toggled 2 cycles before the step edge
    dir_in = 1'b1;
    tick(2);
    applyStimulus(4, 16);
    checkOutput("viol_err", {31'h0, setup_err}, 32'h1);
    checkOutput("viol_pos", pos, 32'd2);
    checkOutput("viol_pvalid", {31'h0, period_valid}, 32'h0);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    tick(1);
    checkOutput("err_cleared", {31'h0, setup_err}, 32'h0);

    // Load alone, then load coinciding with a step event (wrap)
    load = 1'b1; pos_val = -32'sd5;
    tick(1);
    load = 1'b0;
    checkOutput("load_neg", pos, 32'hFFFF_FFFB);
    step_in = 1'b1;
    tick(2);
    load = 1'b1; pos_val = 32'sh7FFF_FFFF;
    tick(1);
    load = 1'b0;
    checkOutput("load_step_wrap", pos, 32'h8000_0000);
    checkOutput("load_step_seen", {31'h0, step_seen}, 32'h1);
    tick(1);
    step_in = 1'b0;
    tick(16);
    checkOutput("load_step_period", {8'h0, period}, 32'd23);
    checkOutput("load_step_pvalid", {31'h0, period_valid}, 32'h1);
    checkOutput("load_step_err", {31'h0, setup_err}, 32'h0);

    // Timeout back to IDLE
    tick(82);
    checkOutput("tmo_before", {31'h0, moving}, 32'h1);
    tick(1);
    checkOutput("tmo_moving", {31'h0, moving}, 32'h0);
    checkOutput("tmo_pvalid", {31'h0, period_valid}, 32'h0);
    applyStimulus(4, 16);
    checkOutput("reent_moving", {31'h0, moving}, 32'h1);
    checkOutput("reent_pvalid", {31'h0, period_valid}, 32'h0);
    checkOutput("reent_pos", pos, 32'h8000_0001);
    applyStimulus(4, 16);
    checkOutput("reent2_pvalid", {31'h0, period_valid}, 32'h1);
    checkOutput("reent2_period", {8'h0, period}, 32'd20);
    checkOutput("reent2_pos", pos, 32'h8000_0002);

    // Asynchronous reset mid-step
    step_in = 1'b1;
    tick(1);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_pos", pos, 32'h0);
    checkOutput("mid_rst_moving", {31'h0, moving}, 32'h0);
    checkOutput("mid_rst_pvalid", {31'h0, period_valid}, 32'h0);
    tick(1);
    step_in = 1'b0;
    reset = 1'b1;
    tick(6);
    checkOutput("post_rst_pos", pos, 32'h0);
    checkOutput("post_rst_seen", {31'h0, step_seen}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
